signal_measure: RTL
===================

Name: signal_measure

Overview:
- Parametrised successor of the scope measurement/control block; sits between the ADC capture path and the VGA renderer/timebase logic.
- Measures min, max, peak-to-peak, midpoint mean and mean-crossing period over fixed sample windows, gated by a sample strobe.
- Publishes each window's results with a one-cycle valid pulse.
- Owns the debounced time/volt/autoscale buttons and the resulting division settings.

Parameters:
- DATA_W, 12, sample width.
- WIN_LEN, 4096, valid samples per measurement window (≥4).
- CNT_W, 16, period counter width.
- HYST, 16, crossing hysteresis in codes.
- DIV_W, 2, width of time_div/volt_div.
- DEBOUNCE, 100, clocks a button must stay low before acting.
- PERIOD_STEP, 10000, samples per time_div step.
- PTP_STEP, 1000, codes per volt_div step.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high.
- sample_valid  in  1  one-cycle strobe; q is valid this cycle.
- q  in  DATA_W  ADC sample (unsigned).
- auto_button, time_button, volt_button  in  1 each  active-low pushbuttons, already synchronised.
- min_out, max_out, ptp_out, mean_out  out  DATA_W  last published window results.
- period_out  out  CNT_W  last published period, in samples.
- period_ok  out  1  period_out is meaningful.
- meas_valid  out  1  one-cycle pulse when results update.
- time_div, volt_div  out  DIV_W  current settings.

Behaviour:
- Reset: every output and internal register is 0; FSM goes to FIRST. A reset mid-window discards partial results.
- FSM FIRST: on sample_valid, min=max=q, count=1, go to ACCUM.
- FSM ACCUM: on each sample_valid, update min and max independently (not else-if) and increment count. When the sample that makes count==WIN_LEN is taken, go to PUBLISH.
- FSM PUBLISH: lasts one cycle and ignores sample_valid that cycle. It registers:
  - min_out, max_out;
  - ptp_out = max-min;
  - mean_out = (max+min)>>1, computed with a DATA_W+1-bit sum and no overflow.
  - It also pulses meas_valid for that cycle, then returns to FIRST.
  - Latency from the last window sample to meas_valid is 1 cycle.
- Threshold: thr = mean_out of the previous published window.
  - Before the first publish there is no threshold: no crossings are detected, and the first window reports period_ok=0.
  - Upper level = thr+HYST, saturating at all-ones; lower level = thr-HYST, saturating at 0.
- Crossing detector:
  - Per valid sample: q < lower sets armed.
  - q ≥ upper with armed set is a rising crossing and clears armed.
- Period counter:
  - Counts valid samples since the last rising crossing and saturates at all-ones.
  - On a crossing: if at least one earlier crossing occurred in this window, the count is latched as the candidate period. The counter then restarts at 1.
  - Saturated candidate → period_ok=0 at publish.
  - At PUBLISH: period_ok=1 iff ≥2 crossings occurred in the window and the candidate is not saturated. period_out = candidate, or 0 if not ok.
  - Crossing state (armed, count, crossing count) clears at PUBLISH.
- Buttons, each independently:
  - The counter increments while the button is low, saturating at DEBOUNCE; high resets it to 0.
  - The action fires exactly once, on the cycle the counter becomes DEBOUNCE.
  - Time and volt actions: div+1, wrapping from all-ones to 0.
- Autoscale:
  - The auto action sets pending.
  - While pending, the cycle after the next meas_valid applies the new settings and clears pending. A press while already pending is a no-op.
  - time_div = smallest k with period_out ≤ (k+1)*PERIOD_STEP, clamped to 2^DIV_W-1. It is unchanged if period_ok=0.
  - volt_div = same rule with ptp_out and PTP_STEP; unchanged if ptp_out=0.
  - Autoscale apply and a manual press in the same cycle: autoscale wins and the manual press is lost.
- All thresholds and step products are computed in CNT_W+DIV_W+1 bits; no truncation.

Test Plan:
- DC input q=2000 for 2 windows, WIN_LEN=64 → meas_valid every 65 valid samples; min=max=mean=2000, ptp=0, period_ok=0.
- Square wave alternating 1000/3000 every 50 samples, WIN_LEN=4096 → window 1: ptp=2000, mean=2000, period_ok=0. Window 2: period_out=100, period_ok=1.
- Same wave with ±10-code noise around mean, HYST=16 → no extra crossings; period_out stays 100.
- Hold time_button low 300 cycles starting from time_div=3 → exactly one step to 0. Release for 1 cycle, press again for 100 cycles → 1. A 99-cycle press → no change.
- Sine with period 25000 samples and ptp 2500, WIN_LEN=65536; press auto → one cycle after the next meas_valid, time_div=2 and volt_div=2. Period 60000 → time_div clamps to 3.
- Assert reset mid-ACCUM → all outputs 0 next cycle. The following window is a first window: period_ok=0, threshold absent.

Source files
------------

// File: rtl/signal_measure.sv
// Windowed min/max/ptp/mean/period measurement plus debounced div buttons and autoscale.
// Latency: results and meas_valid appear 1 cycle after the last window sample; autoscale applies 1 cycle after meas_valid.
// Backpressure: none; the sample arriving during the publish cycle is dropped, and samples are otherwise always accepted.
module signal_measure #(
    parameter int DATA_W      = 12,
    parameter int WIN_LEN     = 4096,
    parameter int CNT_W       = 16,
    parameter int HYST        = 16,
    parameter int DIV_W       = 2,
    parameter int DEBOUNCE    = 100,
    parameter int PERIOD_STEP = 10000,
    parameter int PTP_STEP    = 1000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] q,
    input  logic              auto_button,
    input  logic              time_button,
    input  logic              volt_button,
    output logic [DATA_W-1:0] min_out,
    output logic [DATA_W-1:0] max_out,
    output logic [DATA_W-1:0] ptp_out,
    output logic [DATA_W-1:0] mean_out,
    output logic [CNT_W-1:0]  period_out,
    output logic              period_ok,
    output logic              meas_valid,
    output logic [DIV_W-1:0]  time_div,
    output logic [DIV_W-1:0]  volt_div
);

    localparam int WCNT_W  = $clog2(WIN_LEN + 1);
    localparam int DB_W    = $clog2(DEBOUNCE + 1);
    localparam int CALC_W  = CNT_W + DIV_W + 1;
    localparam int DIV_MAX = (1 << DIV_W) - 1;

    localparam logic [DATA_W-1:0] DATA_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'(WIN_LEN - 1);
    localparam logic [DB_W-1:0]   DB_FULL  = DB_W'(DEBOUNCE);
    localparam logic [DB_W-1:0]   DB_FIRE  = DB_W'(DEBOUNCE - 1);
    localparam logic [CALC_W-1:0] P_STEP   = CALC_W'(PERIOD_STEP);
    localparam logic [CALC_W-1:0] V_STEP   = CALC_W'(PTP_STEP);

    typedef enum logic [1:0] {
        ST_FIRST   = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic [DATA_W-1:0]   min_q, min_d, max_q, max_d;
    logic [DATA_W-1:0]   min_out_q, min_out_d, max_out_q, max_out_d;
    logic [DATA_W-1:0]   ptp_out_q, ptp_out_d, mean_out_q, mean_out_d;
    logic [CNT_W-1:0]    period_out_q, period_out_d;
    logic                period_ok_q, period_ok_d;
    logic                meas_valid_q, meas_valid_d;
    logic                have_thr_q, have_thr_d;
    logic                armed_q, armed_d, armed_n;
    logic [CNT_W-1:0]    per_cnt_q, per_cnt_d, per_n;
    logic [CNT_W-1:0]    cand_q, cand_d, cand_n;
    logic [1:0]          xing_q, xing_d, xing_n;
    logic [DB_W-1:0]     auto_cnt_q, auto_cnt_d, time_cnt_q, time_cnt_d, volt_cnt_q, volt_cnt_d;
    logic                pending_q, pending_d;
    logic [DIV_W-1:0]    time_div_q, time_div_d, volt_div_q, volt_div_d;

    logic                take, done;
    logic [31:0]         upper_w;
    logic [DATA_W-1:0]   upper, lower;
    logic [DATA_W:0]     mean_sum;
    logic                auto_fire, time_fire, volt_fire, apply;

    // Debounce counter: clears while released, saturates at DEBOUNCE while held.
    function automatic logic [DB_W-1:0] db_next(input logic btn, input logic [DB_W-1:0] c);
        if (btn) return '0;
        if (c == DB_FULL) return c;
        return c + DB_W'(1);
    endfunction

    // Smallest k with v <= (k+1)*step, clamped to the largest division setting.
    function automatic logic [DIV_W-1:0] pick_div(input logic [CALC_W-1:0] v, input logic [CALC_W-1:0] step);
        logic [DIV_W-1:0] k;
        k = DIV_W'(DIV_MAX);
        for (int i = DIV_MAX - 1; i >= 0; i--) begin
            if (v <= CALC_W'(i + 1) * step) k = DIV_W'(i);
        end
        return k;
    endfunction

    // A sample counts unless it lands in the publish cycle; done marks the window's last sample.
    assign take = sample_valid && (state_q != ST_PUBLISH);
    assign done = (state_q == ST_ACCUM) && sample_valid && (win_cnt_q == WIN_LAST);

    // Hysteresis levels around the previous window's midpoint, saturating at both rails.
    assign upper_w = 32'(mean_out_q) + 32'(HYST);
    assign upper   = (upper_w > 32'(DATA_MAX)) ? DATA_MAX : upper_w[DATA_W-1:0];
    assign lower   = (32'(mean_out_q) >= 32'(HYST)) ? DATA_W'(32'(mean_out_q) - 32'(HYST)) : '0;

    // Window FSM next state and running min/max.
    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        min_d     = min_q;
        max_d     = max_q;
        case (state_q)
            ST_FIRST: begin
                if (sample_valid) begin
                    min_d     = q;
                    max_d     = q;
                    win_cnt_d = WCNT_W'(1);
                    state_d   = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (sample_valid) begin
                    if (q < min_q) min_d = q;
                    if (q > max_q) max_d = q;
                    win_cnt_d = win_cnt_q + WCNT_W'(1);
                    if (done) state_d = ST_PUBLISH;
                end
            end
            ST_PUBLISH: begin
                win_cnt_d = '0;
                state_d   = ST_FIRST;
            end
            default: state_d = ST_FIRST;
        endcase
    end

    // Rising-crossing detector and inter-crossing sample counter.
    always_comb begin
        armed_n = armed_q;
        per_n   = per_cnt_q;
        cand_n  = cand_q;
        xing_n  = xing_q;
        if (take) begin
            per_n = (per_cnt_q == CNT_MAX) ? CNT_MAX : per_cnt_q + CNT_W'(1);
            if (have_thr_q) begin
                if (armed_q && (q >= upper)) begin
                    armed_n = 1'b0;
                    if (xing_q != 2'd0) cand_n = per_cnt_q;
                    per_n  = CNT_W'(1);
                    xing_n = (xing_q == 2'd2) ? 2'd2 : xing_q + 2'd1;
                end else if (q < lower) begin
                    armed_n = 1'b1;
                end
            end
        end
    end

    assign mean_sum = {1'b0, max_d} + {1'b0, min_d};

    // Publish results on the window's last sample; crossing state restarts for the next window.
    always_comb begin
        armed_d      = done ? 1'b0 : armed_n;
        per_cnt_d    = done ? '0 : per_n;
        cand_d       = done ? '0 : cand_n;
        xing_d       = done ? 2'd0 : xing_n;
        have_thr_d   = have_thr_q | done;
        min_out_d    = min_out_q;
        max_out_d    = max_out_q;
        ptp_out_d    = ptp_out_q;
        mean_out_d   = mean_out_q;
        period_out_d = period_out_q;
        period_ok_d  = period_ok_q;
        meas_valid_d = done;
        if (done) begin
            min_out_d    = min_d;
            max_out_d    = max_d;
            ptp_out_d    = max_d - min_d;
            mean_out_d   = DATA_W'(mean_sum >> 1);
            period_ok_d  = (xing_n == 2'd2) && (cand_n != CNT_MAX);
            period_out_d = period_ok_d ? cand_n : '0;
        end
    end

    assign auto_fire = !auto_button && (auto_cnt_q == DB_FIRE);
    assign time_fire = !time_button && (time_cnt_q == DB_FIRE);
    assign volt_fire = !volt_button && (volt_cnt_q == DB_FIRE);
    assign apply     = pending_q && meas_valid_q;

    // Buttons and autoscale; an autoscale apply swallows a simultaneous manual step.
    always_comb begin
        auto_cnt_d = db_next(auto_button, auto_cnt_q);
        time_cnt_d = db_next(time_button, time_cnt_q);
        volt_cnt_d = db_next(volt_button, volt_cnt_q);
        time_div_d = time_div_q;
        volt_div_d = volt_div_q;
        pending_d  = pending_q | auto_fire;
        if (apply) begin
            pending_d = 1'b0;
            if (period_ok_q) time_div_d = pick_div(CALC_W'(period_out_q), P_STEP);
            if (ptp_out_q != '0) volt_div_d = pick_div(CALC_W'(ptp_out_q), V_STEP);
        end else begin
            if (time_fire) time_div_d = time_div_q + DIV_W'(1);
            if (volt_fire) volt_div_d = volt_div_q + DIV_W'(1);
        end
    end

    // All state registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= ST_FIRST;
            win_cnt_q    <= '0;
            min_q        <= '0;
            max_q        <= '0;
            min_out_q    <= '0;
            max_out_q    <= '0;
            ptp_out_q    <= '0;
            mean_out_q   <= '0;
            period_out_q <= '0;
            period_ok_q  <= 1'b0;
            meas_valid_q <= 1'b0;
            have_thr_q   <= 1'b0;
            armed_q      <= 1'b0;
            per_cnt_q    <= '0;
            cand_q       <= '0;
            xing_q       <= 2'd0;
            auto_cnt_q   <= '0;
            time_cnt_q   <= '0;
            volt_cnt_q   <= '0;
            pending_q    <= 1'b0;
            time_div_q   <= '0;
            volt_div_q   <= '0;
        end else begin
            state_q      <= state_d;
            win_cnt_q    <= win_cnt_d;
            min_q        <= min_d;
            max_q        <= max_d;
            min_out_q    <= min_out_d;
            max_out_q    <= max_out_d;
            ptp_out_q    <= ptp_out_d;
            mean_out_q   <= mean_out_d;
            period_out_q <= period_out_d;
            period_ok_q  <= period_ok_d;
            meas_valid_q <= meas_valid_d;
            have_thr_q   <= have_thr_d;
            armed_q      <= armed_d;
            per_cnt_q    <= per_cnt_d;
            cand_q       <= cand_d;
            xing_q       <= xing_d;
            auto_cnt_q   <= auto_cnt_d;
            time_cnt_q   <= time_cnt_d;
            volt_cnt_q   <= volt_cnt_d;
            pending_q    <= pending_d;
            time_div_q   <= time_div_d;
            volt_div_q   <= volt_div_d;
        end
    end

    assign min_out    = min_out_q;
    assign max_out    = max_out_q;
    assign ptp_out    = ptp_out_q;
    assign mean_out   = mean_out_q;
    assign period_out = period_out_q;
    assign period_ok  = period_ok_q;
    assign meas_valid = meas_valid_q;
    assign time_div   = time_div_q;
    assign volt_div   = volt_div_q;

endmodule
